// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 interrupt controller: register offsets,
// FSM state encoding, spurious-vector low bits and the priority encoder.
package z80_bus_pkg;

  localparam logic [1:0] REG_MASK  = 2'd0;
  localparam logic [1:0] REG_VBASE = 2'd1;
  localparam logic [1:0] REG_PEND  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } intc_state_e;

  // Low vector bits returned when an acknowledge arrives with nothing to serve.
  localparam logic [2:0] SPUR_LSB = 3'b110;

  // Bit 0 has the highest priority.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] r;
    if (v[0])      r = 2'd0;
    else if (v[1]) r = 2'd1;
    else if (v[2]) r = 2'd2;
    else           r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/z80_intc_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line plus a
// rising-edge detector on the synchronised value.
module z80_intc_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic src,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic dly_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      dly_p2  <= 1'b0;
    end else begin
      sync_p0 <= src;
      sync_p1 <= sync_p0;
      dly_p2  <= sync_p1;
    end
  end

  // stage p2 boundary: edge is the synchronised level against its previous value
  assign rise = sync_p1 & ~dly_p2;

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 mode-2 style interrupt controller: 4 sources, MASK/VBASE/PEND registers.
// Optional macro INTC_READBACK_EN enables I/O readback of the three registers.
import z80_bus_pkg::*;

module z80_int_ctrl #(
  parameter logic [7:0] PORT_BASE = 8'h40,
  parameter int         NSRC      = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            mreq,
  input  logic            ioreq,
  input  logic            rd,
  input  logic            wr,
  input  logic            m1,
  input  logic [7:0]      addr,
  input  logic [7:0]      data_to_io,
  input  logic [NSRC-1:0] irq_src,
  output logic [7:0]      data_from_io,
  output logic            int_n,
  output logic [1:0]      ack_idx
);

  localparam logic [7:0] ADDR_MASK  = PORT_BASE + {6'd0, REG_MASK};
  localparam logic [7:0] ADDR_VBASE = PORT_BASE + {6'd0, REG_VBASE};
  localparam logic [7:0] ADDR_PEND  = PORT_BASE + {6'd0, REG_PEND};

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pending_d;
  logic [NSRC-1:0] pend_ack_clr;
  logic [NSRC-1:0] pend_wr_clr;
  logic [NSRC-1:0] mask_lo;
  logic [NSRC-1:0] masked;
  logic [7:3]      vbase;
  logic [7:0]      rd_data;
  logic [1:0]      idx_d;
  logic            wr_q;
  logic            io_cyc;
  logic            wr_stb;
  logic            rd_cyc;
  logic            ack_cyc;
  intc_state_e     state;
  intc_state_e     state_d;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    z80_intc_edge u_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .src     (irq_src[i]),
      .rise    (rise[i])
    );
  end

  // I/O strobes are honoured only while no memory cycle is active.
  assign io_cyc  = ~ioreq & mreq;
  assign wr_stb  = io_cyc & m1 & ~wr & wr_q;
  assign rd_cyc  = io_cyc & m1 & ~rd;
  assign ack_cyc = ~ioreq & ~m1;
  assign masked  = pending & mask_lo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_q <= 1'b1;
    else          wr_q <= wr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_lo <= '0;
      vbase   <= '0;
    end else begin
      if (wr_stb && addr == ADDR_MASK)  mask_lo <= data_to_io[NSRC-1:0];
      if (wr_stb && addr == ADDR_VBASE) vbase   <= data_to_io[7:3];
    end
  end

`ifdef INTC_READBACK_EN
  logic [7:NSRC] mask_hi;
  logic [2:0]    vbase_lo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_hi  <= '0;
      vbase_lo <= '0;
    end else begin
      if (wr_stb && addr == ADDR_MASK)  mask_hi  <= data_to_io[7:NSRC];
      if (wr_stb && addr == ADDR_VBASE) vbase_lo <= data_to_io[2:0];
    end
  end

  always_comb begin
    rd_data = 8'hFF;
    if (addr == ADDR_MASK)       rd_data = {mask_hi, mask_lo};
    else if (addr == ADDR_VBASE) rd_data = {vbase, vbase_lo};
    else if (addr == ADDR_PEND)  rd_data = {{(8-NSRC){1'b0}}, pending};
  end
`else
  assign rd_data = 8'hFF;
`endif

  assign pend_wr_clr = (wr_stb && addr == ADDR_PEND) ? data_to_io[NSRC-1:0] : '0;
  // A fresh edge wins over any clear landing in the same clock.
  assign pending_d   = (pending & ~(pend_ack_clr | pend_wr_clr)) | rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      pending <= '0;
      ack_idx <= 2'd0;
    end else begin
      state   <= state_d;
      pending <= pending_d;
      ack_idx <= idx_d;
    end
  end

  always_comb begin
    state_d      = state;
    idx_d        = ack_idx;
    pend_ack_clr = '0;
    unique case (state)
      ST_IDLE: if (|masked) state_d = ST_REQ;
      ST_REQ: begin
        if (masked == '0) begin
          state_d = ST_IDLE;
        end else if (ack_cyc) begin
          state_d             = ST_ACK;
          idx_d               = lowest_idx(masked);
          pend_ack_clr[idx_d] = 1'b1;
        end
      end
      ST_ACK:  if (ioreq) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign int_n = (state != ST_REQ);

  // Output is gated by reset so the vector drops without waiting for a clock.
  always_comb begin
    data_from_io = 8'hFF;
    if (!reset_n)                          data_from_io = 8'hFF;
    else if (state == ST_ACK)              data_from_io = {vbase, ack_idx, 1'b0};
    else if (state == ST_IDLE && ack_cyc)  data_from_io = {vbase, SPUR_LSB};
    else if (rd_cyc)                       data_from_io = rd_data;
  end

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Self-checking bench for z80_int_ctrl: behavioural model, per-cycle compare,
// directed scenarios and a randomized bus/interrupt phase.
`timescale 1ns/1ps
module tb_z80_int_ctrl;

  localparam logic [7:0] BASE = 8'h40;
`ifdef INTC_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mreq = 1'b1, ioreq = 1'b1, rd = 1'b1, wr = 1'b1, m1 = 1'b1;
  logic [7:0] addr = 8'h00, data_to_io = 8'h00;
  logic [3:0] irq_src = 4'h0;
  logic [7:0] data_from_io;
  logic       int_n;
  logic [1:0] ack_idx;

  z80_int_ctrl #(.PORT_BASE(BASE), .NSRC(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mreq         (mreq),
    .ioreq        (ioreq),
    .rd           (rd),
    .wr           (wr),
    .m1           (m1),
    .addr         (addr),
    .data_to_io   (data_to_io),
    .irq_src      (irq_src),
    .data_from_io (data_from_io),
    .int_n        (int_n),
    .ack_idx      (ack_idx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Behavioural model: 0 = idle, 1 = requesting, 2 = acknowledging.
  int         m_phase = 0;
  logic [7:0] m_mask = 8'h00, m_vbase = 8'h00;
  logic [3:0] m_pend = 4'h0;
  logic [1:0] m_idx = 2'd0;
  logic       m_wr_prev = 1'b1;
  logic [3:0] seen [3];
  logic [3:0] m_rise, m_clr, m_live;
  logic       m_wstb;

  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) seen[i] = 4'h0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_phase = 0; m_mask = 8'h00; m_vbase = 8'h00; m_pend = 4'h0;
        m_idx = 2'd0; m_wr_prev = 1'b1;
        for (int i = 0; i < 3; i++) seen[i] = 4'h0;
      end else begin
        // an edge is the input seen two clocks ago high and three clocks ago low
        m_rise = seen[1] & ~seen[2];
        seen[2] = seen[1]; seen[1] = seen[0]; seen[0] = irq_src;
        m_wstb = !ioreq && m1 && !wr && m_wr_prev;
        m_wr_prev = wr;
        m_live = m_pend & m_mask[3:0];
        m_clr = 4'h0;
        case (m_phase)
          0: if (m_live != 0) m_phase = 1;
          1: begin
            if (m_live == 0) m_phase = 0;
            else if (!ioreq && !m1) begin
              m_idx = first_set(m_live);
              m_clr[m_idx] = 1'b1;
              m_phase = 2;
            end
          end
          default: if (ioreq) m_phase = 0;
        endcase
        if (m_wstb) begin
          if (addr == BASE)          m_mask  = data_to_io;
          if (addr == 8'(BASE + 1))  m_vbase = data_to_io;
          if (addr == 8'(BASE + 2))  m_clr   = m_clr | data_to_io[3:0];
        end
        m_pend = (m_pend & ~m_clr) | m_rise;
      end
    end
  end

  function automatic logic [7:0] exp_data();
    if (!reset_n) return 8'hFF;
    if (m_phase == 2) return {m_vbase[7:3], m_idx, 1'b0};
    if (m_phase == 0 && !ioreq && !m1) return {m_vbase[7:3], 3'b110};
    if (RB && !ioreq && m1 && !rd) begin
      if (addr == BASE)         return m_mask;
      if (addr == 8'(BASE + 1)) return m_vbase;
      if (addr == 8'(BASE + 2)) return {4'h0, m_pend};
    end
    return 8'hFF;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_data", data_from_io, exp_data());
      check("cyc_int_n", {7'b0, int_n}, {7'b0, m_phase != 1});
      check("cyc_ack_idx", {6'b0, ack_idx}, {6'b0, m_idx});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] d);
    ioreq = 1'b0; m1 = 1'b1; wr = 1'b1; addr = port; data_to_io = d;
    tick(); wr = 1'b0;
    tick(); tick();
    wr = 1'b1; ioreq = 1'b1;
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] v);
    ioreq = 1'b0; m1 = 1'b1; rd = 1'b0; addr = port;
    @(negedge clk) v = data_from_io;
    tick();
    rd = 1'b1; ioreq = 1'b1;
  endtask

  task automatic ack(output logic [7:0] v, output logic in_n);
    ioreq = 1'b0; m1 = 1'b0;
    tick();
    @(negedge clk); v = data_from_io; in_n = int_n;
    tick();
    ioreq = 1'b1; m1 = 1'b1;
    tick();
  endtask

  task automatic wait_int(input logic lvl, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int_n == lvl) begin hit = 1'b1; break; end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL %s: int_n never reached %0d within %0d clk", name, lvl, budget);
    end
    tick();
  endtask

  task automatic hold_int(input logic lvl, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, {7'b0, int_n}, {7'b0, lvl});
    end
    tick();
  endtask

  logic [7:0] v;
  logic       in_n;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_data", data_from_io, 8'hFF);
    check("rst_int_n", {7'b0, int_n}, 8'h01);
    check("rst_ack_idx", {6'b0, ack_idx}, 8'h00);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();

    // single source with vector base A0
    io_write(BASE, 8'h0F);
    io_write(8'(BASE + 1), 8'hA0);
    irq_src[2] = 1'b1;
    wait_int(1'b0, 6, "irq2_int_low");
    irq_src[2] = 1'b0;
    ack(v, in_n);
    check("irq2_vector", v, 8'hA4);
    check("irq2_ack_int_n", {7'b0, in_n}, 8'h01);
    check("irq2_ack_idx", {6'b0, ack_idx}, 8'h02);
    hold_int(1'b1, 3, "irq2_cleared");

    // two simultaneous sources served in priority order
    irq_src = 4'b1010;
    wait_int(1'b0, 6, "dual_int_low");
    irq_src = 4'b0000;
    ack(v, in_n);
    check("dual_first", v, 8'hA2);
    wait_int(1'b0, 4, "dual_second_low");
    ack(v, in_n);
    check("dual_second", v, 8'hA6);
    hold_int(1'b1, 3, "dual_done");

    // masked source stays pending until unmasked
    io_write(BASE, 8'h00);
    irq_src[0] = 1'b1;
    tick(); tick(); tick(); tick();
    irq_src[0] = 1'b0;
    hold_int(1'b1, 3, "masked_quiet");
    io_write(BASE, 8'h01);
    wait_int(1'b0, 3, "unmask_int_low");

    // edge coincident with a PEND write-1-to-clear keeps the bit
    irq_src[0] = 1'b1;
    tick();
    io_write(8'(BASE + 2), 8'h01);
    irq_src[0] = 1'b0;
    hold_int(1'b0, 3, "coincident_keep");
    ack(v, in_n);
    check("coincident_vector", v, 8'hA0);

    // PEND readback
    io_write(BASE, 8'h00);
    io_write(8'(BASE + 2), 8'h0F);
    irq_src = 4'b0101;
    tick(); tick(); tick(); tick();
    irq_src = 4'b0000;
    tick(); tick();
    io_read(8'(BASE + 2), v);
    check("read_pend", v, RB ? 8'h05 : 8'hFF);
    io_read(8'(BASE + 1), v);
    check("read_vbase", v, RB ? 8'hA0 : 8'hFF);

    // reset in the middle of an acknowledge
    io_write(8'(BASE + 2), 8'h0F);
    io_write(BASE, 8'h0F);
    irq_src[1] = 1'b1;
    wait_int(1'b0, 6, "rst_ack_int_low");
    irq_src[1] = 1'b0;
    ioreq = 1'b0; m1 = 1'b0;
    tick();
    #2;
    check("pre_rst_vector", data_from_io, 8'hA2);
    reset_n = 1'b0;
    #1;
    check("async_rst_data", data_from_io, 8'hFF);
    check("async_rst_int_n", {7'b0, int_n}, 8'h01);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_int_n", {7'b0, int_n}, 8'h01);
      check("post_rst_spurious", data_from_io, 8'h06);
    end
    tick();
    ioreq = 1'b1; m1 = 1'b1;
    tick();

    // randomized traffic
    io_write(8'(BASE + 1), 8'($urandom));
    io_write(BASE, 8'($urandom));
    for (int it = 0; it < 400; it++) begin
      int op;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
      op = $urandom_range(0, 9);
      if (op <= 1) io_write(8'(BASE + $urandom_range(0, 3)), 8'($urandom));
      else if (op <= 3 && int_n == 1'b0) ack(v, in_n);
      else if (op == 4) ack(v, in_n);
      else if (op == 5) io_read(8'(BASE + $urandom_range(0, 3)), v);
      else tick();
    end
    irq_src = 4'h0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
